ram_io_unit: RTL and testbench

- Parametrised data-memory and memory-mapped I/O unit for the next-generation CPU core. It replaces the fixed 8-word RAM decode/write-back pair and the single 16-bit I/O port.
- Serves one load/store request per cycle over a REQ/ACK handshake, with one cycle of latency.
- Provides configurable RAM depth and configurable input/output port counts. Input ports pass through 2-flop synchronisers.
- Performs an automatic RAM clear sweep after reset and on command.

---
 rtl/ram_io_unit.sv | 169 ++++++++++++++++
 tb/tb_ram_io_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_io_unit.sv
// Data RAM plus memory-mapped input/output ports behind a one-cycle REQ/ACK handshake.
// After reset, and whenever CLR is pulsed, the RAM is zeroed by a sweep while BUSY is held high.
module ram_io_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned IO_BASE = 64,
    parameter int unsigned N_IN    = 2,
    parameter int unsigned N_OUT   = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    REQ,
    input  logic                    WE,
    input  logic [ADDR_W-1:0]       ADDR,
    input  logic [DATA_W-1:0]       WDATA,
    input  logic                    CLR,
    output logic                    BUSY,
    output logic                    ACK,
    output logic [DATA_W-1:0]       RDATA,
    output logic                    ERR,
    input  logic [N_IN*DATA_W-1:0]  IO_IN,
    output logic [N_OUT*DATA_W-1:0] IO_OUT
);
    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AXW    = ADDR_W + 1;
    localparam int unsigned N_MAX  = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam logic [AXW-1:0]    DEPTH_A  = AXW'(DEPTH);
    localparam logic [AXW-1:0]    BASE_A   = AXW'(IO_BASE);
    localparam logic [RAM_AW-1:0] PTR_LAST = RAM_AW'(DEPTH - 1);

    if (DEPTH > IO_BASE || 64'(IO_BASE) + 64'(N_MAX) > (64'(1) << ADDR_W) ||
        N_IN < 1 || N_OUT < 1) begin : g_bad_params
        $error("ram_io_unit: illegal parameter combination");
    end

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                     state_q, state_d;
    logic [RAM_AW-1:0]          ptr_q, ptr_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic [N_OUT*DATA_W-1:0]    io_out_q, io_out_d;
    logic [N_IN*DATA_W-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DATA_W-1:0]          mem_q [DEPTH];

    logic                       mem_we;
    logic [RAM_AW-1:0]          mem_waddr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [AXW-1:0]             addr_x;
    logic                       in_ram, in_hit, out_hit;
    logic [DATA_W-1:0]          in_val;

    // Address decode over the full address width; no aliasing.
    always_comb begin
        addr_x  = {1'b0, ADDR};
        in_ram  = addr_x < DEPTH_A;
        in_hit  = 1'b0;
        out_hit = 1'b0;
        in_val  = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (addr_x == BASE_A + AXW'(i)) begin
                in_hit = 1'b1;
                in_val = sync2_q[i*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < int'(N_OUT); j++) begin
            if (addr_x == BASE_A + AXW'(j)) begin
                out_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        io_out_d  = io_out_q;
        sync1_d   = IO_IN;
        sync2_d   = sync1_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (CLR) begin
                    ptr_d = '0;
                end else if (ptr_q == PTR_LAST) begin
                    ptr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    ptr_d = ptr_q + RAM_AW'(1);
                end
            end
            default: begin
                // CLR wins over a simultaneous request, which then stays pending.
                if (CLR) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end else if (REQ) begin
                    ack_d = 1'b1;
                    if (WE) begin
                        if (in_ram) begin
                            mem_we    = 1'b1;
                            mem_waddr = ADDR[RAM_AW-1:0];
                            mem_wdata = WDATA;
                        end else if (out_hit) begin
                            for (int j = 0; j < int'(N_OUT); j++) begin
                                if (addr_x == BASE_A + AXW'(j)) begin
                                    io_out_d[j*DATA_W +: DATA_W] = WDATA;
                                end
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if (in_ram) begin
                            rdata_d = mem_q[ADDR[RAM_AW-1:0]];
                        end else if (in_hit) begin
                            rdata_d = in_val;
                        end else begin
                            rdata_d = '0;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_CLEAR;
            ptr_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            io_out_q <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            io_out_q <= io_out_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    // RAM array is deliberately unreset; the sweep zeroes it.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign BUSY   = (state_q == S_CLEAR);
    assign ACK    = ack_q;
    assign ERR    = err_q;
    assign RDATA  = rdata_q;
    assign IO_OUT = io_out_q;
endmodule

// File: tb/tb_ram_io_unit.sv
// Scoreboard bench for ram_io_unit: a cycle-level reference model pushes expected
// responses on acceptance; a negedge monitor pops and compares whenever ACK is seen.
module tb_ram_io_unit;
    logic        CLK = 1'b0;
    logic        RESET, REQ, WE, CLR;
    logic [7:0]  ADDR;
    logic [15:0] WDATA;
    logic        BUSY, ACK, ERR;
    logic [15:0] RDATA;
    logic [31:0] IO_IN, IO_OUT;

    int errors = 0;
    int checks = 0;

    ram_io_unit dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .CLR(CLR), .BUSY(BUSY), .ACK(ACK), .RDATA(RDATA), .ERR(ERR),
        .IO_IN(IO_IN), .IO_OUT(IO_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct { logic [15:0] rdata; logic err; } exp_t;
    exp_t        exp_q [$];
    logic [15:0] m_mem [64];
    logic [31:0] hist [$];
    logic [31:0] m_io_out = '0;
    logic [15:0] m_rdata = '0;
    int          busy_left = 64;

    always @(posedge CLK or posedge RESET) begin : model
        logic [31:0] syncv;
        exp_t        e;
        int          a;
        if (RESET) begin
            busy_left = 64;
            hist.delete();
            exp_q.delete();
            m_io_out = '0;
            m_rdata  = '0;
        end else begin
            // Inputs as seen through two flops: the sample taken two edges ago.
            syncv = (hist.size() >= 2) ? hist[hist.size()-2] : 32'h0;
            hist.push_back(IO_IN);
            if (hist.size() > 3) void'(hist.pop_front());
            if (REQ && busy_left == 0 && !CLR) begin
                a = int'(ADDR);
                e.err = 1'b0;
                if (WE) begin
                    if (a < 64) m_mem[a] = WDATA;
                    else if (a >= 64 && a < 66) m_io_out[(a-64)*16 +: 16] = WDATA;
                    else e.err = 1'b1;
                end else begin
                    if (a < 64) m_rdata = m_mem[a];
                    else if (a >= 64 && a < 66) m_rdata = syncv[(a-64)*16 +: 16];
                    else begin m_rdata = '0; e.err = 1'b1; end
                end
                e.rdata = m_rdata;
                exp_q.push_back(e);
            end
            if (CLR) busy_left = 64;
            else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) foreach (m_mem[i]) m_mem[i] = '0;
            end
        end
    end

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RESET) begin
            chk("busy", 64'(BUSY), 64'(busy_left != 0));
            chk("io_out", 64'(IO_OUT), 64'(m_io_out));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ack", 64'(ACK), 64'(1));
                chk("rdata", 64'(RDATA), 64'(e.rdata));
                chk("err", 64'(ERR), 64'(e.err));
            end else begin
                chk("ack_idle", 64'(ACK), 64'(0));
                chk("err_idle", 64'(ERR), 64'(0));
                chk("rdata_hold", 64'(RDATA), 64'(m_rdata));
            end
        end
    end

    // Holds the request until ACK; returns at posedge+1 with ACK just seen.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                         input logic clr, output int n);
        n = 0;
        REQ = 1'b1; WE = we; ADDR = addr; WDATA = wd; CLR = clr;
        do begin
            @(posedge CLK); #1;
            CLR = 1'b0;
            n++;
        end while (!ACK && n < 300);
        checks++;
        if (!ACK) begin
            errors++;
            $display("FAIL req_timeout: no ACK for addr %0h after %0d cycles", addr, n);
        end
    endtask

    task automatic idle();
        REQ = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic busy_len(input string name);
        int n = 0;
        while (BUSY && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        chk(name, 64'(n), 64'(64));
    endtask

    initial begin
        int n;
        logic [7:0] a;
        RESET = 1'b1; REQ = 1'b0; WE = 1'b0; CLR = 1'b0;
        ADDR = '0; WDATA = '0; IO_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 64'(BUSY), 64'(1));
        chk("rst_ack", 64'(ACK), 64'(0));
        chk("rst_rdata", 64'(RDATA), 64'(0));
        chk("rst_io_out", 64'(IO_OUT), 64'(0));
        RESET = 1'b0;
        busy_len("busy_after_reset");

        for (int i = 0; i < 64; i++) issue(1'b0, 8'(i), 16'h0, 1'b0, n);
        idle();

        issue(1'b1, 8'd5, 16'h1234, 1'b0, n);
        issue(1'b0, 8'd5, 16'h0, 1'b0, n);
        chk("raw_back_to_back", 64'(n), 64'(1));
        chk("raw_data", 64'(RDATA), 64'(16'h1234));
        idle();

        IO_IN = 32'hBEEF_0000;
        repeat (3) idle();
        issue(1'b0, 8'd65, 16'h0, 1'b0, n);
        chk("io_in_read", 64'(RDATA), 64'(16'hBEEF));
        IO_IN = 32'h1111_0000;
        issue(1'b0, 8'd65, 16'h0, 1'b0, n);
        chk("io_in_sync_delay", 64'(RDATA), 64'(16'hBEEF));
        idle();

        issue(1'b1, 8'd64, 16'h00A5, 1'b0, n);
        issue(1'b1, 8'd65, 16'h5A00, 1'b0, n);
        chk("io_out_value", 64'(IO_OUT), 64'(32'h5A00_00A5));
        issue(1'b0, 8'd64, 16'h0, 1'b0, n);
        issue(1'b0, 8'd66, 16'h0, 1'b0, n);
        chk("read_66_err", 64'(ERR), 64'(1));
        issue(1'b1, 8'd100, 16'hFFFF, 1'b0, n);
        chk("write_100_err", 64'(ERR), 64'(1));
        chk("write_100_io_out", 64'(IO_OUT), 64'(32'h5A00_00A5));
        idle();

        issue(1'b1, 8'd3, 16'h7777, 1'b0, n);
        idle();
        issue(1'b0, 8'd3, 16'h0, 1'b1, n);
        chk("clr_req_latency", 64'(n), 64'(66));
        chk("clr_read_zero", 64'(RDATA), 64'(0));
        idle();

        issue(1'b0, 8'd65, 16'h0, 1'b0, n);
        REQ = 1'b0; CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        repeat (20) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("async_rst_busy", 64'(BUSY), 64'(1));
        chk("async_rst_rdata", 64'(RDATA), 64'(0));
        chk("async_rst_io_out", 64'(IO_OUT), 64'(0));
        chk("async_rst_ack", 64'(ACK), 64'(0));
        @(posedge CLK); #1;
        RESET = 1'b0;
        busy_len("busy_after_mid_reset");

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) IO_IN = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    a = 8'($urandom_range(0, 63));
                2:       a = 8'($urandom_range(62, 68));
                default: a = 8'($urandom_range(0, 255));
            endcase
            issue(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 59) == 0), n);
            if ($urandom_range(0, 3) == 0) idle();
        end
        repeat (3) idle();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
